sbox_share_sched: RTL

Scheduler that time-shares one pipelined AES S-box between two requesters: the round datapath (SubBytes, 16 bytes) and the key expansion (SubWord, 4 bytes). The S-box is the composite-field unit built around the GF(2^4) inverter and sits outside this block. The block grants one requester at a time, streams its bytes into the S-box at one byte per cycle and reassembles the substituted bytes. It then returns the result with a one-cycle acknowledge.

---
 rtl/sbox_share_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sbox_share_sched.sv
// Time-shares one external pipelined AES S-box between the round datapath
// (16-byte SubBytes) and the key schedule (4-byte SubWord), one byte per cycle.
module sbox_share_sched #(
   parameter int SBOX_LAT = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req,
   input  logic [127:0] st_data,
   output logic         st_ack,
   output logic [127:0] st_result,
   input  logic         ks_req,
   input  logic [31:0]  ks_word,
   output logic         ks_ack,
   output logic [31:0]  ks_result,
   output logic [7:0]   sb_in,
   output logic         sb_valid,
   input  logic [7:0]   sb_out,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                   state_q, state_d;
   logic                     gnt_ks_q, gnt_ks_d;
   logic                     prio_ks_q, prio_ks_d;
   logic [127:0]             shreg_q, shreg_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [SBOX_LAT-1:0]      dl_vld_q, dl_vld_d;
   logic [SBOX_LAT-1:0][3:0] dl_idx_q, dl_idx_d;
   logic [127:0]             st_res_q, st_res_d;
   logic [31:0]              ks_res_q, ks_res_d;

   logic       issue, cap, pick_ks;
   logic [3:0] last_idx, cap_idx;

   assign issue    = (state_q == ISSUE);
   assign last_idx = gnt_ks_q ? 4'd3 : 4'd15;
   assign cap      = dl_vld_q[SBOX_LAT-1];
   assign cap_idx  = dl_idx_q[SBOX_LAT-1];
   // With both requests pending the pointer decides; a lone request always wins.
   assign pick_ks  = ks_req && (!st_req || prio_ks_q);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      gnt_ks_d  = gnt_ks_q;
      prio_ks_d = prio_ks_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (st_req || ks_req) begin
               gnt_ks_d  = pick_ks;
               prio_ks_d = !pick_ks;
               shreg_d   = pick_ks ? {96'b0, ks_word} : st_data;
               cnt_d     = 4'd0;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            shreg_d = {8'b0, shreg_q[127:8]};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == last_idx) state_d = DRAIN;
         end
         DRAIN: begin
            if (cap && (cap_idx == last_idx)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Tag line: byte index travels alongside its byte through the S-box pipeline.
   always_comb begin
      dl_vld_d    = dl_vld_q;
      dl_idx_d    = dl_idx_q;
      dl_vld_d[0] = issue;
      dl_idx_d[0] = cnt_q;
      for (int i = 1; i < SBOX_LAT; i++) begin
         dl_vld_d[i] = dl_vld_q[i-1];
         dl_idx_d[i] = dl_idx_q[i-1];
      end
   end

   always_comb begin
      st_res_d = st_res_q;
      ks_res_d = ks_res_q;
      if (cap) begin
         if (gnt_ks_q) ks_res_d[{cap_idx[1:0], 3'b000} +: 8] = sb_out;
         else          st_res_d[{cap_idx, 3'b000} +: 8]      = sb_out;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_ks_q  <= 1'b0;
         prio_ks_q <= 1'b1;
         shreg_q   <= '0;
         cnt_q     <= '0;
         // NOTE: the tag line is reset so S-box outputs still in flight are dropped.
         dl_vld_q  <= '0;
         dl_idx_q  <= '0;
         st_res_q  <= '0;
         ks_res_q  <= '0;
      end else begin
         state_q   <= state_d;
         gnt_ks_q  <= gnt_ks_d;
         prio_ks_q <= prio_ks_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         dl_vld_q  <= dl_vld_d;
         dl_idx_q  <= dl_idx_d;
         st_res_q  <= st_res_d;
         ks_res_q  <= ks_res_d;
      end
   end

   assign sb_valid  = issue;
   assign sb_in     = issue ? shreg_q[7:0] : 8'h00;
   assign busy      = (state_q != IDLE);
   assign st_ack    = (state_q == DONE) && !gnt_ks_q;
   assign ks_ack    = (state_q == DONE) && gnt_ks_q;
   assign st_result = st_res_q;
   assign ks_result = ks_res_q;

endmodule
